// File: rtl/line_fill_responder_if.sv
// rtl/line_fill_responder_if.sv - cache line-fill request and word-bus signals between cache, responder and memory
interface line_fill_responder_if #(
    parameter int LINE_BITS = 256
);
    logic [31:0]          addr_i;
    logic                 rd_i;
    logic [LINE_BITS-1:0] data_o;
    logic                 ack_o;
    logic                 hw_page_fault_o;
    logic [31:0]          mem_addr_o;
    logic                 mem_rd_o;
    logic [31:0]          mem_data_i;
    logic                 mem_ack_i;
    logic                 mem_err_i;

    modport slave (
        input  addr_i, rd_i, mem_data_i, mem_ack_i, mem_err_i,
        output data_o, ack_o, hw_page_fault_o, mem_addr_o, mem_rd_o
    );

    modport master (
        output addr_i, rd_i, mem_data_i, mem_ack_i, mem_err_i,
        input  data_o, ack_o, hw_page_fault_o, mem_addr_o, mem_rd_o
    );
endinterface

// File: rtl/line_fill_responder.sv
// rtl/line_fill_responder.sv - fetches a 256-bit line as eight 32-bit words and returns it with a one-cycle ack
module line_fill_responder #(
    parameter int          LINE_BITS  = 256,
    parameter logic [31:0] ADDR_LIMIT = 32'h1000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    line_fill_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t               state_q, state_n;
    logic [26:0]          line_q, line_n;
    logic [2:0]           k_q, k_n;
    logic [6:0][31:0]     buf_q, buf_n;
    logic                 ack_q, ack_n;
    logic                 pf_q, pf_n;
    logic                 mem_rd_q, mem_rd_n;
    logic [31:0]          mem_addr_q, mem_addr_n;
    logic [LINE_BITS-1:0] data_q, data_n;

    // Low address bits select a byte within the line and are never used.
    logic unused_low_addr;
    assign unused_low_addr = ^bus.addr_i[4:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            line_q     <= '0;
            k_q        <= '0;
            buf_q      <= '0;
            ack_q      <= 1'b0;
            pf_q       <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_n;
            line_q     <= line_n;
            k_q        <= k_n;
            buf_q      <= buf_n;
            ack_q      <= ack_n;
            pf_q       <= pf_n;
            mem_rd_q   <= mem_rd_n;
            mem_addr_q <= mem_addr_n;
            data_q     <= data_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        line_n     = line_q;
        k_n        = k_q;
        buf_n      = buf_q;
        ack_n      = 1'b0;
        pf_n       = 1'b0;
        mem_rd_n   = mem_rd_q;
        mem_addr_n = mem_addr_q;
        data_n     = data_q;
        case (state_q)
            IDLE: begin
                if (bus.rd_i) begin
                    line_n = bus.addr_i[31:5];
                    k_n    = 3'd0;
                    if ({bus.addr_i[31:5], 5'b0} < ADDR_LIMIT) begin
                        state_n    = FETCH;
                        mem_rd_n   = 1'b1;
                        mem_addr_n = {bus.addr_i[31:5], 5'b0};
                    end else begin
                        // Unmapped line: answer immediately without touching memory.
                        state_n = RESP;
                        ack_n   = 1'b1;
                        pf_n    = 1'b1;
                        data_n  = '0;
                    end
                end
            end
            FETCH: begin
                if (bus.mem_err_i) begin
                    state_n  = RESP;
                    mem_rd_n = 1'b0;
                    ack_n    = 1'b1;
                    pf_n     = 1'b1;
                    data_n   = '0;
                end else if (bus.mem_ack_i) begin
                    if (k_q == 3'd7) begin
                        // Last word goes straight to the output; only words 0-6 need buffering.
                        state_n  = RESP;
                        mem_rd_n = 1'b0;
                        ack_n    = 1'b1;
                        data_n   = {bus.mem_data_i, buf_q};
                    end else begin
                        buf_n[k_q] = bus.mem_data_i;
                        k_n        = k_q + 3'd1;
                        mem_addr_n = {line_q, k_q + 3'd1, 2'b00};
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n  = IDLE;
                mem_rd_n = 1'b0;
            end
        endcase
    end

    assign bus.data_o          = data_q;
    assign bus.ack_o           = ack_q;
    assign bus.hw_page_fault_o = pf_q;
    assign bus.mem_addr_o      = mem_addr_q;
    assign bus.mem_rd_o        = mem_rd_q;
endmodule

// File: tb/tb_line_fill_responder.sv
// tb/tb_line_fill_responder.sv - randomized self-checking bench for line_fill_responder
module tb_line_fill_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    line_fill_responder_if bus ();
    line_fill_responder dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    bit pat    = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (pat) return 32'hA000_0000 + {29'b0, a[4:2]};
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One line fill as seen by the cache and memory. err_w: word that returns a bus
    // error (-1 none); rst_w: word during which reset is pulsed (-1 none).
    task automatic fill(input logic [31:0] a, input int wmin, input int wmax,
                        input int err_w, input int rst_w);
        logic [255:0] exp_line;
        int  waits[8];
        int  exp_cyc, served, n, wc, cyc;
        bit  oor, got, flt;
        n = 0; wc = 0; cyc = 0; got = 0;
        oor = ({a[31:5], 5'b0} >= 32'h1000_0000);
        for (int k = 0; k < 8; k++) begin
            waits[k] = $urandom_range(wmax, wmin);
            exp_line[32*k +: 32] = mem_fn({a[31:5], k[2:0], 2'b00});
        end
        served  = (err_w >= 0 && err_w < 8) ? err_w + 1 : 8;
        flt     = oor || (err_w >= 0 && err_w < 8);
        exp_cyc = 1;
        if (!oor) for (int k = 0; k < served; k++) exp_cyc += waits[k] + 1;
        if (flt) exp_line = '0;
        if (oor) served = 0;

        bus.addr_i = a;
        bus.rd_i   = 1'b1;
        while (cyc < 300 && !got) begin
            @(negedge clk);
            cyc++;
            bus.mem_ack_i = 1'b0;
            bus.mem_err_i = 1'b0;
            if (bus.ack_o) begin
                got = 1;
                check("ack_cycle", cyc, exp_cyc);
                check("fault", bus.hw_page_fault_o, flt);
                check("line", bus.data_o, exp_line);
                check("words_served", n, served);
                check("mem_rd_at_ack", bus.mem_rd_o, 1'b0);
                bus.rd_i = 1'b0;
            end else if (bus.mem_rd_o) begin
                if (oor || n >= served) begin
                    check("spurious_mem_rd", bus.mem_rd_o, 1'b0);
                end else begin
                    check("mem_addr", bus.mem_addr_o, {a[31:5], n[2:0], 2'b00});
                    if (n == rst_w) begin
                        rst = 1'b0;
                        @(negedge clk);
                        check("rst_mem_rd", bus.mem_rd_o, 1'b0);
                        check("rst_ack", bus.ack_o, 1'b0);
                        check("rst_mem_addr", bus.mem_addr_o, 32'h0);
                        rst = 1'b1;
                        return;
                    end
                    if (wc == waits[n]) begin
                        if (n == err_w) bus.mem_err_i = 1'b1;
                        else begin
                            bus.mem_ack_i  = 1'b1;
                            bus.mem_data_i = mem_fn(bus.mem_addr_o);
                        end
                        n++;
                        wc = 0;
                    end else begin
                        wc++;
                    end
                end
                bus.addr_i = $urandom;
            end
        end
        if (!got) begin
            check("ack_timeout", 1'b0, 1'b1);
            bus.rd_i = 1'b0;
        end else begin
            @(negedge clk);
            check("ack_one_cycle", bus.ack_o, 1'b0);
            check("fault_cleared", bus.hw_page_fault_o, 1'b0);
            check("line_held", bus.data_o, exp_line);
        end
    endtask

    initial begin
        bus.addr_i     = '0;
        bus.rd_i       = 1'b0;
        bus.mem_data_i = '0;
        bus.mem_ack_i  = 1'b0;
        bus.mem_err_i  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack_o", bus.ack_o, 1'b0);
        check("rst_fault", bus.hw_page_fault_o, 1'b0);
        check("rst_mem_rd_o", bus.mem_rd_o, 1'b0);
        check("rst_mem_addr_o", bus.mem_addr_o, 32'h0);
        check("rst_data_o", bus.data_o, 256'h0);
        rst = 1'b1;

        pat = 1'b1;
        fill(32'h0000_1234, 0, 0, -1, -1);
        pat = 1'b0;
        fill(32'h0000_0040, 2, 2, -1, -1);
        fill(32'h1000_0020, 0, 0, -1, -1);
        fill(32'h0000_0200, 0, 1, 3, -1);
        fill(32'h0000_0600, 0, 1, -1, 4);
        fill(32'h0000_0600, 0, 1, -1, -1);
        fill(32'h0000_0100, 0, 0, -1, -1);
        fill(32'h0000_0300, 0, 0, -1, -1);
        fill(32'h0FFF_FFFF, 1, 1, -1, -1);
        fill(32'hFFFF_FFE0, 0, 0, -1, -1);
        fill(32'h0000_0800, 0, 0, 0, -1);
        fill(32'h0000_0840, 0, 2, 7, -1);

        for (int i = 0; i < 25; i++) begin
            logic [31:0] a;
            int e;
            a = ($urandom_range(3, 0) == 0) ? $urandom : ($urandom & 32'h0FFF_FFFF);
            e = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            fill(a, 0, 3, e, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
